// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width defaults and Gray/binary conversion.
// Used by both the read and the write pointer controllers.
package fifo_pkg;

  localparam int unsigned ADDR_SIZE_DFLT  = 8;
  localparam int unsigned DATA_WIDTH_DFLT = 8;
  localparam int unsigned PTR_MAX_W       = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Pointers narrower than PTR_MAX_W are zero-extended, so the upper bits stay zero.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int unsigned i = PTR_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-side controller: read pointer, write-pointer sync, empty/level
// flags and a first-word-fall-through output stage with a one-entry skid buffer.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = fifo_pkg::ADDR_SIZE_DFLT,
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH_DFLT,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_SIZE:0]    wr_ptr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  ready_i,
  output logic [ADDR_SIZE:0]    ptr_o,
  output logic [ADDR_SIZE-1:0]  addr_o,
  output logic                  mem_rd_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  empty_o,
  output logic [ADDR_SIZE:0]    level_o,
  output logic                  almost_empty_o
);

  localparam int unsigned PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0]         wq2;
  logic [PW-1:0]         wq2_bin;
  logic [PW-1:0]         rd_bin_q, rd_bin_d;
  logic [PW-1:0]         rd_gray_q, rd_gray_d;
  logic [PW-1:0]         level_q, level_d;
  logic                  ram_empty_q, ram_empty_d;
  logic                  ae_q, ae_d;
  logic                  pending_q;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]            occ;
  logic                  pop;
  logic                  fetch;

  sync_2ff #(.W(PW)) u_wptr_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (wr_ptr_i),
    .q_o   (wq2)
  );

  always_comb begin
    occ   = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    pop   = out_valid_q & ready_i;
    // occ + pending - pop < 2, rearranged to avoid unsigned underflow.
    fetch = ~ram_empty_q &
            (({1'b0, occ} + {2'b00, pending_q}) < (3'd2 + {2'b00, pop}));

    rd_bin_d    = rd_bin_q + {{ADDR_SIZE{1'b0}}, fetch};
    rd_gray_d   = PW'(bin2gray(ptr_word_t'(rd_bin_d)));
    ram_empty_d = (rd_gray_d == wq2);
    wq2_bin     = PW'(gray2bin(ptr_word_t'(wq2)));
    level_d     = wq2_bin - rd_bin_d;
    ae_d        = (level_d <= AE_LVL);

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (pending_q) begin
      if (!out_valid_q || pop) begin
        out_valid_d = 1'b1;
        if (pop && skid_valid_q) begin
          // Skid word is older than the returning RAM word, so it goes out first.
          out_data_d  = skid_data_q;
          skid_data_d = mem_data_i;
        end else begin
          out_data_d  = mem_data_i;
        end
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = mem_data_i;
      end
    end else if (pop) begin
      out_valid_d  = skid_valid_q;
      out_data_d   = skid_valid_q ? skid_data_q : out_data_q;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      ram_empty_q  <= 1'b1;
      pending_q    <= 1'b0;
      level_q      <= '0;
      ae_q         <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      ram_empty_q  <= ram_empty_d;
      pending_q    <= fetch;
      level_q      <= level_d;
      ae_q         <= ae_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign ptr_o          = rd_gray_q;
  assign addr_o         = rd_bin_q[ADDR_SIZE-1:0];
  assign mem_rd_en_o    = fetch;
  assign data_o         = out_data_q;
  assign valid_o        = out_valid_q;
  assign empty_o        = ~out_valid_q;
  assign level_o        = level_q;
  assign almost_empty_o = ae_q;

endmodule
